// File: rtl/branch_predictor_bp.sv
// Dynamic branch predictor: tagged BTB plus saturating-counter pattern table,
// optionally indexed gshare-style with a global history register. Lookups are
// combinational from registered state; training happens at the edge ending an
// EX-stage resolve cycle.
module branch_predictor_bp #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned TAG_BITS = 8,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned GHR_BITS = 0
) (
  input  logic                                      clk,
  input  logic                                      reset,
  // IF-stage lookup
  input  logic                                      if_valid,
  input  logic                                      if_stall,
  input  logic [XLEN-1:0]                           if_pc,
  output logic                                      pred_taken,
  output logic [XLEN-1:0]                           pred_target,
  output logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0] pred_ghr,
  // EX-stage resolve / training
  input  logic                                      upd_valid,
  input  logic                                      upd_is_jump,
  input  logic [XLEN-1:0]                           upd_pc,
  input  logic [XLEN-1:0]                           upd_target,
  input  logic                                      upd_taken,
  input  logic                                      upd_pred_taken,
  input  logic [XLEN-1:0]                           upd_pred_target,
  input  logic [((GHR_BITS > 0) ? GHR_BITS : 1)-1:0] upd_ghr,
  output logic                                      upd_mispredict,
  output logic [XLEN-1:0]                           redirect_pc,
  // Statistics
  output logic [XLEN-1:0]                           perf_lookups,
  output logic [XLEN-1:0]                           perf_mispredicts
);

  localparam int unsigned IDX = $clog2(ENTRIES);
  localparam int unsigned GW  = (GHR_BITS > 0) ? GHR_BITS : 1;

  // Weakly not-taken start value and saturation ceiling of the direction counters
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  // Predictor state
  logic [ENTRIES-1:0]  r_valid;
  logic [ENTRIES-1:0]  r_is_jump;
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];
  logic [CTR_BITS-1:0] r_ctr    [ENTRIES];
  logic [GW-1:0]       r_ghr;
  logic [XLEN-1:0]     r_perf_lookups;
  logic [XLEN-1:0]     r_perf_mispredicts;

  // Lookup-side wires
  logic [IDX-1:0]      w_bidx;
  logic [IDX-1:0]      w_pidx;
  logic [IDX-1:0]      w_hist_idx;
  logic [TAG_BITS-1:0] w_if_tag;
  logic                w_hit;
  logic                w_lk_jump;
  logic                w_lk_ctr_taken;
  logic                w_lookup_fire;
  logic [XLEN-1:0]     w_if_pc_plus4;

  // Update-side wires
  logic [IDX-1:0]      w_uidx;
  logic [IDX-1:0]      w_upidx;
  logic [IDX-1:0]      w_uhist_idx;
  logic [TAG_BITS-1:0] w_upd_tag;
  logic                w_btb_we;
  logic                w_ctr_we;
  logic [CTR_BITS-1:0] w_ctr_cur;
  logic [CTR_BITS-1:0] w_ctr_next;
  logic [GW-1:0]       w_ghr_next;

  // PC bits outside the index/tag fields are deliberately ignored
  logic                w_unused_pc_bits;
  assign w_unused_pc_bits = ^{if_pc, upd_pc};

  // History folded onto the index width; bimodal mode contributes nothing
  assign w_hist_idx  = (GHR_BITS == 0) ? '0 : IDX'(r_ghr);
  assign w_uhist_idx = (GHR_BITS == 0) ? '0 : IDX'(upd_ghr);

  // Lookup indexing and tag compare
  assign w_bidx         = if_pc[IDX+1:2];
  assign w_pidx         = w_bidx ^ w_hist_idx;
  assign w_if_tag       = if_pc[IDX+2 +: TAG_BITS];
  assign w_hit          = r_valid[w_bidx] && (r_tag[w_bidx] == w_if_tag);
  assign w_lk_jump      = r_is_jump[w_bidx];
  assign w_lk_ctr_taken = r_ctr[w_pidx][CTR_BITS-1];
  assign w_lookup_fire  = if_valid & ~if_stall;
  assign w_if_pc_plus4  = if_pc + XLEN'(4);

  // Prediction outputs
  assign pred_taken  = if_valid & w_hit & (w_lk_jump | w_lk_ctr_taken);
  assign pred_target = pred_taken ? r_target[w_bidx] : w_if_pc_plus4;
  assign pred_ghr    = r_ghr;

  // Resolve: compare actual outcome against what IF predicted
  assign upd_mispredict = upd_valid &
                          ((upd_taken != upd_pred_taken) |
                           (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)));
  assign redirect_pc    = upd_taken ? upd_target : (upd_pc + XLEN'(4));

  // Training indices and enables; reset suppresses any training this cycle
  assign w_uidx    = upd_pc[IDX+1:2];
  assign w_upidx   = w_uidx ^ w_uhist_idx;
  assign w_upd_tag = upd_pc[IDX+2 +: TAG_BITS];
  assign w_btb_we  = upd_valid & upd_taken & ~reset;
  assign w_ctr_we  = upd_valid & ~upd_is_jump;

  // Saturating increment/decrement of the trained direction counter
  always_comb begin
    w_ctr_cur  = r_ctr[w_upidx];
    w_ctr_next = w_ctr_cur;
    if (upd_taken) begin
      if (w_ctr_cur != CTR_MAX) begin
        w_ctr_next = w_ctr_cur + CTR_BITS'(1);
      end
    end else if (w_ctr_cur != '0) begin
      w_ctr_next = w_ctr_cur - CTR_BITS'(1);
    end
  end

  // Global history next value: mispredict repair beats speculative lookup shift
  always_comb begin
    w_ghr_next = r_ghr;
    if (GHR_BITS == 0) begin
      w_ghr_next = '0;
    end else if (upd_mispredict & ~upd_is_jump) begin
      w_ghr_next = GW'({upd_ghr, upd_taken});
    end else if (upd_mispredict) begin
      w_ghr_next = upd_ghr;
    end else if (w_lookup_fire & w_hit & ~w_lk_jump) begin
      w_ghr_next = GW'({r_ghr, pred_taken});
    end
  end

  // Control state: valid bits, counters, history and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= CTR_INIT;
      end
      r_ghr              <= '0;
      r_perf_lookups     <= '0;
      r_perf_mispredicts <= '0;
    end else begin
      if (w_btb_we) begin
        r_valid[w_uidx] <= 1'b1;
      end
      if (w_ctr_we) begin
        r_ctr[w_upidx] <= w_ctr_next;
      end
      r_ghr              <= w_ghr_next;
      r_perf_lookups     <= r_perf_lookups + XLEN'(w_lookup_fire);
      r_perf_mispredicts <= r_perf_mispredicts + XLEN'(upd_mispredict);
    end
  end

  // BTB payload: only meaningful behind a valid bit, so it carries no reset
  always_ff @(posedge clk) begin
    if (w_btb_we) begin
      r_tag[w_uidx]     <= w_upd_tag;
      r_is_jump[w_uidx] <= upd_is_jump;
      r_target[w_uidx]  <= upd_target;
    end
  end

  assign perf_lookups     = r_perf_lookups;
  assign perf_mispredicts = r_perf_mispredicts;

endmodule
